// File: rtl/decode_queue.sv
// Buffered MIPS decode stage: DEPTH-entry instruction FIFO with combinational decode of the head.
// Optional zero-latency bypass when empty: define DECODE_QUEUE_BYPASS_EN.
package cpu_types_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04,
                         OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU= 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B, OP_LL   = 6'h30,
                         OP_SC    = 6'h38;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL  = 6'h02, FN_JR  = 6'h08, FN_ADD = 6'h20,
                         FN_ADDU= 6'h21, FN_SUB  = 6'h22, FN_SUBU= 6'h23, FN_AND = 6'h24,
                         FN_OR  = 6'h25, FN_XOR  = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A,
                         FN_SLTU= 6'h2B;
  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;
endpackage

package diaosi_types_pkg;
  typedef enum logic [1:0] {SRC_RDAT2, SRC_EXT, SRC_SHAMT} alusrc_t;
  typedef enum logic {ZEROEXT, SIGNEXT} extop_t;
  typedef enum logic [1:0] {PC_ADD4, PC_JUMP, PC_JR, PC_BRANCH} pcsrc_t;
  typedef enum logic [1:0] {W_ALUOUT, W_DATA, W_LUI, W_R31} wmux_t;
  typedef enum logic {ZS_BEQ, ZS_BNE} zsel_t;
endpackage

module decode_queue
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output aluop_t           alu_op,
  output alusrc_t          ALUSrc,
  output extop_t           ExtOP,
  output pcsrc_t           PCSrc,
  output wmux_t            W_mux,
  output zsel_t            zero_sel,
  output logic [4:0]       rsel1,
  output logic [4:0]       rsel2,
  output logic [4:0]       wsel,
  output logic             wen,
  output logic             d_ren,
  output logic             d_wen,
  output logic             d_atomic,
  output logic [15:0]      imm16,
  output logic [4:0]       shamt,
  output logic [25:0]      j_addr26,
  output logic [31:0]      lui,
  output logic             halt,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, halted_d;
  logic [31:0]      mem_instr_q [DEPTH];
  logic [31:0]      mem_pc_q    [DEPTH];

  logic        nonempty, bypass, push, pop, wr_en, rd_en, head_halt;
  logic [31:0] head_instr, head_pc;

  assign nonempty = (count_q != '0);
`ifdef DECODE_QUEUE_BYPASS_EN
  assign bypass = !nonempty && !halted_q && !flush && in_valid;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready   = (count_q < CNT_W'(DEPTH)) && !halted_q;
  assign out_valid  = (nonempty && !halted_q) || bypass;
  assign head_instr = bypass ? in_instr : mem_instr_q[rd_ptr_q];
  assign head_pc    = bypass ? in_pc    : mem_pc_q[rd_ptr_q];
  assign head_halt  = (head_instr == 32'hFFFF_FFFF);

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  // A bypassed instruction that is consumed immediately never touches storage.
  assign wr_en = push && !(bypass && pop) && !flush;
  assign rd_en = pop && !bypass && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      if (pop && head_halt) halted_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_instr_q[wr_ptr_q] <= in_instr;
      mem_pc_q[wr_ptr_q]    <= in_pc;
    end
  end

  logic [5:0] op, fn;
  logic [4:0] rt, rd;
  logic       ill, wen_c, dren_c, dwen_c, dat_c;

  assign op       = head_instr[31:26];
  assign fn       = head_instr[5:0];
  assign rt       = head_instr[20:16];
  assign rd       = head_instr[15:11];
  assign rsel1    = head_instr[25:21];
  assign shamt    = head_instr[10:6];
  assign imm16    = head_instr[15:0];
  assign j_addr26 = head_instr[25:0];
  assign lui      = {head_instr[15:0], 16'h0000};
  assign out_pc   = head_pc;

  always_comb begin
    alu_op   = ALU_ADD;
    ALUSrc   = SRC_EXT;
    ExtOP    = SIGNEXT;
    PCSrc    = PC_ADD4;
    W_mux    = W_ALUOUT;
    zero_sel = ZS_BEQ;
    wsel     = rt;
    rsel2    = 5'd0;
    wen_c    = 1'b1;
    dren_c   = 1'b0;
    dwen_c   = 1'b0;
    dat_c    = 1'b0;
    ill      = 1'b0;
    case (op)
      OP_RTYPE: begin
        ALUSrc = SRC_RDAT2;
        wsel   = rd;
        rsel2  = rt;
        case (fn)
          FN_SLL:          begin alu_op = ALU_SLL; ALUSrc = SRC_SHAMT; end
          FN_SRL:          begin alu_op = ALU_SRL; ALUSrc = SRC_SHAMT; end
          FN_JR:           begin PCSrc = PC_JR; wen_c = 1'b0; end
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          default:         ill = 1'b1;
        endcase
      end
      OP_J:     begin PCSrc = PC_JUMP; wen_c = 1'b0; end
      OP_JAL:   begin PCSrc = PC_JUMP; wsel = 5'd31; W_mux = W_R31; end
      OP_BEQ, OP_BNE: begin
        alu_op   = ALU_SUB;
        ALUSrc   = SRC_RDAT2;
        rsel2    = rt;
        PCSrc    = PC_BRANCH;
        zero_sel = (op == OP_BNE) ? ZS_BNE : ZS_BEQ;
        wen_c    = 1'b0;
      end
      OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
      OP_SLTI:  alu_op = ALU_SLT;
      OP_SLTIU: alu_op = ALU_SLTU;
      OP_ANDI:  begin alu_op = ALU_AND; ExtOP = ZEROEXT; end
      OP_ORI:   begin alu_op = ALU_OR;  ExtOP = ZEROEXT; end
      OP_XORI:  begin alu_op = ALU_XOR; ExtOP = ZEROEXT; end
      OP_LUI:   W_mux = W_LUI;
      OP_LW:    begin dren_c = 1'b1; W_mux = W_DATA; end
      OP_LL:    begin dren_c = 1'b1; dat_c = 1'b1; W_mux = W_DATA; end
      OP_SW:    begin dwen_c = 1'b1; rsel2 = rt; wen_c = 1'b0; end
      OP_SC:    begin dwen_c = 1'b1; dat_c = 1'b1; rsel2 = rt; W_mux = W_DATA; end
      default:  ill = !head_halt;
    endcase
    // Halt and illegal words behave as NOPs.
    if (ill || head_halt) begin
      wen_c  = 1'b0;
      dren_c = 1'b0;
      dwen_c = 1'b0;
      dat_c  = 1'b0;
      PCSrc  = PC_ADD4;
    end
  end

  assign wen      = out_valid && wen_c;
  assign d_ren    = out_valid && dren_c;
  assign d_wen    = out_valid && dwen_c;
  assign d_atomic = out_valid && dat_c;
  assign halt     = out_valid && head_halt;
  assign illegal  = out_valid && ill;
  assign halted   = halted_q;
  assign count    = count_q;

endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered, parametrised instruction decode stage for the pipelined MIPS core. It accepts fetched instructions with their PC through a valid/ready handshake and holds them in a DEPTH-entry FIFO. It presents the fully decoded control bundle of the FIFO head to the execute stage, with flush, stall and sticky-halt handling. It adds illegal-instruction detection and LL/SC decode. All encodings come from cpu_types_pkg and diaosi_types_pkg.

## Interface
- DEPTH, 2, FIFO entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), occupancy counter width
- CLK  in  1  rising-edge clock
- nRST  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers in_instr/in_pc
- in_ready  out  1  queue accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  PC of in_instr
- flush  in  1  taken branch/jump from EX: discard everything
- out_ready  in  1  EX accepts head (low = stall)
- out_valid  out  1  head bundle valid
- out_pc  out  32  PC of head
- alu_op, ALUSrc, ExtOP, PCSrc, W_mux, zero_sel  out  enum widths  control selects
- rsel1, rsel2, wsel  out  5  register selects
- wen, d_ren, d_wen, d_atomic  out  1  register-file / dcache enables
- imm16  out  16, shamt  out  5, j_addr26  out  26, lui  out  32  instruction fields
- halt  out  1  head is 0xFFFFFFFF
- illegal  out  1  head has unknown opcode/funct
- halted  out  1  sticky: halt consumed
- count  out  CNT_W  occupancy

## Operation
- Push when in_valid && in_ready. Pop when out_valid && out_ready. Circular read/write pointers wrap modulo DEPTH.
- in_ready = (count < DEPTH) && !halted. There is no same-cycle pass-through when full.
- out_valid = (count != 0) && !halted.
- Decode of the head is combinational:
  - ALU ops: ADD/ADDU/ADDI/ADDIU/LW/LL/SW/SC→ADD; SUB/SUBU/BEQ/BNE→SUB; AND/ANDI, OR/ORI, XOR/XORI, NOR, SLT/SLTI, SLTU/SLTIU map directly; SLL/SRL use ALUSrc=SHAMT.
  - ALUSrc: RTYPE/BEQ/BNE use RDAT2; all other opcodes use EXT. ExtOP is ZEROEXT for ANDI/ORI/XORI, SIGNEXT otherwise.
  - wsel: rd for RTYPE, 31 for JAL, rt otherwise. rsel2 is rt for RTYPE/BEQ/BNE/SW/SC, 0 otherwise.
  - PCSrc: JR→JR, J/JAL→JUMP, BEQ/BNE→BRANCH (zero_sel BEQ/BNE).
  - W_mux: LW/LL/SC→DATA, LUI→LUI, JAL→R31, otherwise ALUOUT.
  - wen=0 for J, JR, BEQ, BNE, SW, halt and illegal.
  - d_ren for LW/LL; d_wen for SW/SC; d_atomic for LL/SC.
- Unknown opcode, or an RTYPE funct outside the supported set: illegal=1, treated as NOP (all enables 0, PCSrc ADD4).
- When out_valid=0: wen, d_ren, d_wen, d_atomic, halt and illegal are forced 0; field outputs are don't-care.
- Halt: when the popped head has halt=1, halted sets at that edge and stays set until nRST. After that, in_ready=0 and out_valid=0. flush does not clear halted.
- Flush: count, rd_ptr and wr_ptr go to 0 at the edge. Any push or pop in the same cycle is discarded; flush has priority.

## Timing
- Reset (async, nRST low): count=0, pointers=0, halted=0, out_valid=0, in_ready=1, all enables 0.
- Latency: an instruction pushed at edge N is presented with out_valid=1 from cycle N+1.
- Throughput: 1 instruction/cycle with out_ready held high.
- Simultaneous push+pop: count unchanged, legal when full only if in_ready was already 1. With count==DEPTH, in_ready=0 even if out_ready=1.
- Stall (out_ready=0): head outputs hold stable; FIFO fills to DEPTH, then in_ready drops.
- Reset mid-operation: contents lost immediately; no partial pop.

## Configuration
- DECODE_QUEUE_BYPASS_EN:
  - Defined: when count==0, !halted, !flush and in_valid, the input instruction is decoded directly.
  - out_valid=1 the same cycle, with out_pc=in_pc.
  - If out_ready=1, the instruction is consumed without being written; otherwise it is pushed normally.
  - Zero-cycle latency when empty.
- Undefined: no bypass; minimum latency is 1 cycle.

## Test plan
- Reset, then push 0x20220005 (ADDI r2,r1,5) at pc 0x0 → next cycle out_valid=1, alu_op=ADD, ALUSrc=EXT, ExtOP=SIGN, wsel=2, rsel1=1, wen=1, imm16=0x0005.
- out_ready=0, push DEPTH instructions → count=DEPTH, in_ready=0; head fields unchanged. Raise out_ready → instructions pop in order, one per cycle.
- Fill 2 entries, assert flush together with in_valid → next cycle count=0, out_valid=0; the pushed word is lost.
- Push 0xC0410000 (LL r1,0(r2)) then 0xE0410000 (SC) → LL: d_ren=1, d_atomic=1, W_mux=DATA. SC: d_wen=1, d_atomic=1, wen=1, rsel2=1.
- Push 0xFFFFFFFF then 0x00000000, pop the halt → halted=1 after the edge, out_valid=0, in_ready=0 until nRST.
- Push opcode 0x3F with a non-halt word (0xFC000000) → illegal=1, wen=0, d_wen=0, PCSrc=ADD4; with DECODE_QUEUE_BYPASS_EN and an empty queue, out_valid=1 in the same cycle.
